// File: rtl/scheduler_fsm.sv
// Annealing-sequence controller: walks RESET -> per-iteration multiply/update -> FIN,
// steering the external scheduler from the counter values it returns.
module scheduler_fsm #(
  parameter  int NN = 800,
  localparam int CW = $clog2(NN)
) (
  input  logic          clk,
  input  logic          rst_sys,
  input  logic          start,
  input  logic          abort,
  input  logic [CW:0]   n_spin,
  input  logic [15:0]   n_iter,
  input  logic [CW-1:0] count_bit,
  input  logic [CW-1:0] count_mult,
  input  logic [CW-1:0] count_spin,
  input  logic [15:0]   count_iter,
  output logic [3:0]    state,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RESET   = 4'd1,
    STMULT  = 4'd2,
    MULT    = 4'd3,
    LMULT   = 4'd4,
    LLMULT  = 4'd5,
    LLLMULT = 4'd6,
    UPDATE  = 4'd7,
    LUPDATE = 4'd8,
    IRESET  = 4'd9,
    FIN     = 4'd10
  } state_e;

  localparam logic [CW:0] SpinMax   = (CW+1)'(NN);
  localparam logic [CW:0] SpinMin   = (CW+1)'(3);
  localparam logic [CW:0] SpinOne   = (CW+1)'(1);
  localparam logic [CW:0] SpinThree = (CW+1)'(3);

  state_e      state_q, state_d;
  logic [CW:0] nSpin_q;
  logic [15:0] nIter_q;
  logic        done_q, done_d;
  logic        cfgErr_q, cfgErr_d;
  logic        startOk;
  logic        cfgValid;

  logic [CW:0] countBitExt, countMultExt, countSpinExt;

  // Counters are zero-extended so they compare against the latched spin count width.
  assign countBitExt  = {1'b0, count_bit};
  assign countMultExt = {1'b0, count_mult};
  assign countSpinExt = {1'b0, count_spin};

  assign cfgValid = (n_spin >= SpinMin) && (n_spin <= SpinMax) && (n_iter != 16'd0);

  always_comb begin
    state_d  = state_q;
    cfgErr_d = 1'b0;
    startOk  = 1'b0;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (cfgValid) begin
              state_d = RESET;
              startOk = 1'b1;
            end else begin
              cfgErr_d = 1'b1;
            end
          end
        end
        RESET:   if (countBitExt == nSpin_q - SpinOne) state_d = IRESET;
        IRESET:  state_d = (count_iter == nIter_q) ? FIN : STMULT;
        STMULT:  state_d = MULT;
        MULT:    if (countMultExt == nSpin_q - SpinThree) state_d = LMULT;
        LMULT:   state_d = LLMULT;
        LLMULT:  state_d = LLLMULT;
        LLLMULT: state_d = UPDATE;
        UPDATE:  state_d = (countSpinExt == nSpin_q - SpinOne) ? LUPDATE : STMULT;
        LUPDATE: state_d = IRESET;
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    done_d = (state_d == FIN);
  end

  // Config is captured only on an accepted start; later input changes wait for the next run.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      state_q  <= IDLE;
      nSpin_q  <= '0;
      nIter_q  <= '0;
      done_q   <= 1'b0;
      cfgErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      cfgErr_q <= cfgErr_d;
      if (startOk) begin
        nSpin_q <= n_spin;
        nIter_q <= n_iter;
      end
    end
  end

  assign state   = state_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign cfg_err = cfgErr_q;

endmodule

// File: tb/tb_scheduler_fsm.sv
// Self-checking bench for scheduler_fsm: a scheduler model closes the counter loop and
// expected state traces are built from the nested spin/iteration loop structure.
module tb_scheduler_fsm;

  localparam int NN = 16;
  localparam int CW = $clog2(NN);

  localparam int S_IDLE    = 0;
  localparam int S_RESET   = 1;
  localparam int S_STMULT  = 2;
  localparam int S_MULT    = 3;
  localparam int S_LMULT   = 4;
  localparam int S_LLMULT  = 5;
  localparam int S_LLLMULT = 6;
  localparam int S_UPDATE  = 7;
  localparam int S_LUPDATE = 8;
  localparam int S_IRESET  = 9;
  localparam int S_FIN     = 10;

  logic          clk = 1'b0;
  logic          rst_sys, start, abort;
  logic [CW:0]   n_spin;
  logic [15:0]   n_iter;
  logic [CW-1:0] count_bit, count_mult, count_spin;
  logic [15:0]   count_iter;
  logic [3:0]    state;
  logic          busy, done, cfg_err;

  int checks = 0;
  int errors = 0;
  int expQ[$];
  int curSpin, curIter;

  always #5 clk = ~clk;

  scheduler_fsm #(.NN(NN)) dut (
    .clk        (clk),
    .rst_sys    (rst_sys),
    .start      (start),
    .abort      (abort),
    .n_spin     (n_spin),
    .n_iter     (n_iter),
    .count_bit  (count_bit),
    .count_mult (count_mult),
    .count_spin (count_spin),
    .count_iter (count_iter),
    .state      (state),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  // Scheduler model: registered counters reflecting the previous cycle's state.
  always @(posedge clk) begin
    if (rst_sys) begin
      count_bit  <= '0;
      count_mult <= '0;
      count_spin <= '0;
      count_iter <= '0;
    end else begin
      count_bit  <= (int'(state) == S_RESET) ? count_bit + 1'b1 : '0;
      count_mult <= (int'(state) == S_MULT)  ? count_mult + 1'b1 : '0;
      if (int'(state) == S_IRESET)      count_spin <= '0;
      else if (int'(state) == S_UPDATE) count_spin <= count_spin + 1'b1;
      if (int'(state) == S_RESET)        count_iter <= '0;
      else if (int'(state) == S_LUPDATE) count_iter <= count_iter + 16'd1;
    end
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int spin, input int iter);
    n_spin = (CW+1)'(spin);
    n_iter = 16'(iter);
    start  = 1'b1;
    waitCycle();
    start  = 1'b0;
  endtask

  // Expected per-cycle states from cycle 1 after the accepted start up to the IDLE after FIN.
  function automatic void buildTrace(input int s, input int it);
    expQ.delete();
    curSpin = s;
    curIter = it;
    for (int i = 0; i < s; i++) expQ.push_back(S_RESET);
    expQ.push_back(S_IRESET);
    for (int k = 0; k < it; k++) begin
      for (int sp = 0; sp < s; sp++) begin
        expQ.push_back(S_STMULT);
        for (int m = 0; m < s - 2; m++) expQ.push_back(S_MULT);
        expQ.push_back(S_LMULT);
        expQ.push_back(S_LLMULT);
        expQ.push_back(S_LLLMULT);
        expQ.push_back(S_UPDATE);
      end
      expQ.push_back(S_LUPDATE);
      expQ.push_back(S_IRESET);
    end
    expQ.push_back(S_FIN);
    expQ.push_back(S_IDLE);
  endfunction

  function automatic int findNth(input int code, input int n);
    int seen = 0;
    for (int i = 0; i < expQ.size(); i++) begin
      if (expQ[i] == code) begin
        seen++;
        if (seen == n) return i;
      end
    end
    return -1;
  endfunction

  // abortMode: 1 = abort only, 2 = abort together with rst_sys.
  task automatic followTrace(input int abortAt, input int abortMode, input bit holdStart,
                             input int changeAt, input int newSpin);
    int fin;
    bit sawUpdate;
    fin = curSpin + 2 + curIter * (curSpin * (curSpin + 3) + 2);
    sawUpdate = 1'b0;
    for (int i = 0; i < expQ.size(); i++) begin
      checkOutput("state", int'(state), expQ[i]);
      checkOutput("busy", int'(busy), int'(expQ[i] != S_IDLE));
      checkOutput("done", int'(done), int'((i + 1) == fin));
      if (expQ[i] == S_UPDATE && !sawUpdate) begin
        sawUpdate = 1'b1;
        checkOutput("spinAtFirstUpdate", int'(count_spin), 0);
      end
      if (i == changeAt) n_spin = (CW+1)'(newSpin);
      if (holdStart && expQ[i] == S_FIN) start = 1'b1;
      if (i == abortAt) begin
        abort = 1'b1;
        if (abortMode == 2) rst_sys = 1'b1;
        waitCycle();
        abort   = 1'b0;
        rst_sys = 1'b0;
        checkOutput("abortState", int'(state), S_IDLE);
        checkOutput("abortBusy", int'(busy), 0);
        checkOutput("abortDone", int'(done), 0);
        checkOutput("abortCfgErr", int'(cfg_err), 0);
        return;
      end
      if (i < expQ.size() - 1) waitCycle();
    end
  endtask

  task automatic checkReject(input int spin, input int iter);
    applyStimulus(spin, iter);
    checkOutput("rejState", int'(state), S_IDLE);
    checkOutput("rejBusy", int'(busy), 0);
    checkOutput("rejCfgErr", int'(cfg_err), 1);
    waitCycle();
    checkOutput("rejCfgErrDrop", int'(cfg_err), 0);
    checkOutput("rejStateAfter", int'(state), S_IDLE);
  endtask

  initial begin
    int s, it, kind, ab;
    rst_sys = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    n_spin  = '0;
    n_iter  = '0;
    repeat (3) waitCycle();
    checkOutput("rstState", int'(state), S_IDLE);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstCfgErr", int'(cfg_err), 0);
    rst_sys = 1'b0;
    abort   = 1'b1;
    waitCycle();
    abort   = 1'b0;
    checkOutput("idleAbort", int'(state), S_IDLE);

    $display("[TB] nominal run n_spin=4 n_iter=2");
    applyStimulus(4, 2);
    buildTrace(4, 2);
    followTrace(-1, 0, 1'b0, -1, 0);

    $display("[TB] config rejection");
    checkReject(2, 1);
    checkReject(NN + 1, 1);
    checkReject(4, 0);

    $display("[TB] abort in third MULT cycle, then restart");
    applyStimulus(8, 1);
    buildTrace(8, 1);
    followTrace(findNth(S_MULT, 3), 1, 1'b0, -1, 0);
    applyStimulus(8, 1);
    buildTrace(8, 1);
    followTrace(-1, 0, 1'b0, -1, 0);

    $display("[TB] reset and abort together in UPDATE");
    applyStimulus(4, 1);
    buildTrace(4, 1);
    followTrace(findNth(S_UPDATE, 1), 2, 1'b0, -1, 0);

    $display("[TB] start held through FIN");
    applyStimulus(3, 1);
    buildTrace(3, 1);
    followTrace(-1, 0, 1'b1, -1, 0);
    waitCycle();
    start = 1'b0;
    buildTrace(3, 1);
    followTrace(-1, 0, 1'b0, -1, 0);

    $display("[TB] boundary n_spin=NN");
    applyStimulus(NN, 1);
    buildTrace(NN, 1);
    followTrace(-1, 0, 1'b0, -1, 0);

    $display("[TB] config latch");
    applyStimulus(4, 1);
    buildTrace(4, 1);
    followTrace(-1, 0, 1'b0, 12, 6);

    $display("[TB] randomized runs");
    for (int r = 0; r < 10; r++) begin
      s    = $urandom_range(3, 10);
      it   = $urandom_range(1, 3);
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        ab = $urandom_range(0, 2);
        if (ab == 0)      checkReject($urandom_range(0, 2), it);
        else if (ab == 1) checkReject($urandom_range(NN + 1, 2 * NN - 1), it);
        else              checkReject(s, 0);
      end else begin
        applyStimulus(s, it);
        buildTrace(s, it);
        if (kind == 1) followTrace($urandom_range(0, expQ.size() - 3), 1, 1'b0, -1, 0);
        else           followTrace(-1, 0, 1'b0, -1, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scheduler_fsm.md
# scheduler_fsm

Annealing-sequence controller for the SSQA core. It generates the 4-bit `state` code that drives the counter/temperature scheduler. It decides every transition from the counter values that scheduler returns. It owns the loop order RESET → per-iteration (per-spin multiply/update) → FIN and exposes start/busy/done handshaking to the host.

## Interface
Parameters:
- `NN`, 800: maximum spin count; counter width `CW = $clog2(NN)`.
- State codes, fixed: `IDLE`=0, `RESET`=1, `STMULT`=2, `MULT`=3, `LMULT`=4, `LLMULT`=5, `LLLMULT`=6, `UPDATE`=7, `LUPDATE`=8, `IRESET`=9, `FIN`=10.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_sys`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; honoured only in IDLE.
- `abort`  in  1  cancel run; any state → IDLE.
- `n_spin`  in  CW+1  active spins for this run; valid range 3..NN.
- `n_iter`  in  16  annealing iterations; valid range 1..65535.
- `count_bit`  in  CW  bit counter from scheduler.
- `count_mult`  in  CW  multiply column counter from scheduler.
- `count_spin`  in  CW  spin index from scheduler.
- `count_iter`  in  16  completed-iteration counter from scheduler.
- `state`  out  4  registered current state code.
- `busy`  out  1  high whenever `state != IDLE`.
- `done`  out  1  registered; high exactly during the FIN cycle.
- `cfg_err`  out  1  registered 1-cycle pulse on a rejected start.

## Operation
- `n_spin`/`n_iter` are latched into internal registers on an accepted start. Later input changes are ignored until the next start.
- Counter inputs are the scheduler's registered outputs. They reflect the state of the previous cycle. All comparisons zero-extend the counters to the latched widths.
- Transitions:
  - IDLE:
    - `start` with a valid config → RESET.
    - `start` with `n_spin<3`, `n_spin>NN` or `n_iter==0` → stay in IDLE, assert `cfg_err` the next cycle.
  - RESET → IRESET when `count_bit == n_spin-1`; otherwise stay.
  - IRESET → FIN if `count_iter == n_iter`; otherwise → STMULT.
  - STMULT → MULT unconditionally.
  - MULT → LMULT when `count_mult == n_spin-3`; otherwise stay.
  - LMULT → LLMULT → LLLMULT → UPDATE, each unconditional.
  - UPDATE → LUPDATE if `count_spin == n_spin-1`; otherwise → STMULT.
  - LUPDATE → IRESET unconditionally.
  - FIN → IDLE unconditionally.
- Entering IRESET from RESET clears the scheduler's spin counter. A run after an abort therefore starts clean.
- The controller never clears `count_comp` or Q. Annealing temperature continues across runs until `rst_sys`.

## Timing
- Reset values: `state`=IDLE, `busy`=0, `done`=0, `cfg_err`=0; latched config = 0.
- Priority: `rst_sys` > `abort` > normal transition. `abort` in IDLE has no effect.
- Cycles per spin = `n_spin+3`: STMULT 1, MULT `n_spin-2`, LMULT 1, LLMULT 1, LLLMULT 1, UPDATE 1.
- Cycles per iteration = `n_spin*(n_spin+3)+2`, including LUPDATE and IRESET.
- Start to FIN: start sampled in cycle 0. RESET occupies cycles 1..`n_spin`, then the initial IRESET. FIN lands at cycle `n_spin + 2 + n_iter*(n_spin*(n_spin+3)+2)`, with IDLE the cycle after.
- `done` and `busy` are Moore outputs, with no combinational path from any input.
- A `start` during FIN is ignored. A new start is accepted only once `state==IDLE`.

## Test plan
- **Nominal run:** `n_spin=4`, `n_iter=2`, start at cycle 0, with a model scheduler in the loop.
  - RESET cycles 1–4; IRESET 5; first STMULT 6; MULT 7–8; LMULT 9; UPDATE 12.
  - LUPDATE 34 and 64; IRESET 35 and 65.
  - FIN/`done` at cycle 66; IDLE at 67.
- **Config rejection:** start with `n_spin=2`, then `n_spin=NN+1`, then `n_iter=0`.
  - Each case: `state` stays IDLE, `busy`=0, `cfg_err` high for exactly one cycle after the start.
- **Abort mid-MULT:** `n_spin=8`, abort asserted in the 3rd MULT cycle.
  - IDLE the next cycle.
  - A restart reproduces the nominal cycle counts; `count_spin` at the first UPDATE is 0.
- **Simultaneous events:** `rst_sys` and `abort` together during UPDATE → IDLE, all outputs at reset values. `start` held through FIN → no new run until IDLE, then accepted.
- **Boundary size:** `n_spin=NN`, `n_iter=1`.
  - MULT lasts NN-2 cycles per spin.
  - `done` at cycle `NN+2+NN*(NN+3)+2`.
- **Config latch:** change `n_spin` from 4 to 6 mid-run → run completes with `n_spin=4` timing.
